// File: rtl/row_assembler.sv
//============================================================================
// Module      : row_assembler
// Description : Collects tagged elements, one per cycle, into a packed row
//               buffer and presents each completed row on a valid/ready
//               output. Elements whose (column,row) tags differ from the next
//               expected position are dropped and raise a sticky seq_error.
//               A one-cycle frame_done pulse follows acceptance of the final
//               row of a frame.
// Revision    : 1.0  initial release
//----------------------------------------------------------------------------
// Ports
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   flush           in   synchronous clear, overrides every other input
//   in_valid        in   element offered
//   in_ready        out  element can be accepted this cycle (FILL state)
//   in_data         in   element value
//   in_width_index  in   column tag of the offered element
//   in_height_index in   row tag of the offered element
//   row_valid       out  assembled row available (HOLD state)
//   row_ready       in   downstream takes the row
//   row_data        out  packed row, element w at [w*ELEM_WIDTH +: ELEM_WIDTH]
//   row_index       out  row number of the presented row
//   frame_done      out  pulse the cycle after the last row is taken
//   seq_error       out  sticky out-of-order tag flag
//============================================================================
`default_nettype none

module row_assembler #(
  parameter int INPUT_WIDTH      = 4,
  parameter int INPUT_HEIGHT     = 3,
  parameter int INPUT_WIDTH_LOG  = (INPUT_WIDTH  > 1) ? $clog2(INPUT_WIDTH)  : 1,
  parameter int INPUT_HEIGHT_LOG = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1,
  parameter int ELEM_WIDTH       = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ELEM_WIDTH-1:0]             in_data,
  input  logic [INPUT_WIDTH_LOG-1:0]        in_width_index,
  input  logic [INPUT_HEIGHT_LOG-1:0]       in_height_index,
  output logic                              row_valid,
  input  logic                              row_ready,
  output logic [INPUT_WIDTH*ELEM_WIDTH-1:0] row_data,
  output logic [INPUT_HEIGHT_LOG-1:0]       row_index,
  output logic                              frame_done,
  output logic                              seq_error
);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [INPUT_WIDTH_LOG-1:0]  LAST_W = INPUT_WIDTH_LOG'(INPUT_WIDTH - 1);
  localparam logic [INPUT_HEIGHT_LOG-1:0] LAST_H = INPUT_HEIGHT_LOG'(INPUT_HEIGHT - 1);

  state_t                      state;
  state_t                      state_next;
  logic [INPUT_WIDTH_LOG-1:0]  exp_w;
  logic [INPUT_HEIGHT_LOG-1:0] exp_h;
  logic                        accept;
  logic                        tag_match;
  logic                        last_elem;
  logic                        row_accept;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    row_valid  = 1'b0;

    tag_match  = (in_width_index == exp_w) && (in_height_index == exp_h);
    last_elem  = (exp_w == LAST_W);

    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && tag_match && last_elem) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        row_valid = 1'b1;
        if (row_ready) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase

    // Flush abandons any held row and restarts collection.
    if (flush) begin
      state_next = FILL;
    end

    accept     = in_valid && in_ready;
    row_accept = row_valid && row_ready;
  end

  // --------------------------------------------------------------------------
  // Datapath: expected-tag counters, row buffer, status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_w      <= '0;
      exp_h      <= '0;
      row_data   <= '0;
      row_index  <= '0;
      seq_error  <= 1'b0;
      frame_done <= 1'b0;
    end else if (flush) begin
      // The row buffer and row_index are left as they are; only the
      // sequencing state is cleared.
      exp_w      <= '0;
      exp_h      <= '0;
      seq_error  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= row_accept && (row_index == LAST_H);

      if (accept) begin
        if (tag_match) begin
          // Slots are written in place; every slot is rewritten before the
          // next HOLD, so no clear between rows is needed.
          row_data[exp_w*ELEM_WIDTH +: ELEM_WIDTH] <= in_data;
          if (last_elem) begin
            exp_w     <= '0;
            row_index <= exp_h;
          end else begin
            exp_w <= exp_w + 1'b1;
          end
        end else begin
          seq_error <= 1'b1;
        end
      end

      if (row_accept) begin
        if (row_index == LAST_H) begin
          exp_h <= '0;
        end else begin
          exp_h <= exp_h + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_row_assembler.sv
//============================================================================
// Module      : tb_row_assembler
// Description : Directed self-checking bench for row_assembler. Expected rows
//               are queued as stimulus is planned and compared when the DUT
//               hands a row over on row_valid && row_ready.
// Revision    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_row_assembler;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int E  = 8;
  localparam int WL = 2;
  localparam int HL = 2;

  typedef struct packed {
    logic [W*E-1:0] data;
    logic [HL-1:0]  idx;
  } row_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [E-1:0]  in_data = '0;
  logic [WL-1:0] in_width_index = '0;
  logic [HL-1:0] in_height_index = '0;
  logic          row_valid;
  logic          row_ready = 1'b0;
  logic [W*E-1:0] row_data;
  logic [HL-1:0] row_index;
  logic          frame_done;
  logic          seq_error;

  row_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   cycles = 0;

  always #5 clk = ~clk;

  row_assembler #(
    .INPUT_WIDTH      (W),
    .INPUT_HEIGHT     (H),
    .INPUT_WIDTH_LOG  (WL),
    .INPUT_HEIGHT_LOG (HL),
    .ELEM_WIDTH       (E)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_width_index  (in_width_index),
    .in_height_index (in_height_index),
    .row_valid       (row_valid),
    .row_ready       (row_ready),
    .row_data        (row_data),
    .row_index       (row_index),
    .frame_done      (frame_done),
    .seq_error       (seq_error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: observe the handshakes that will happen at the coming edge,
  // score any row being handed over, then check frame_done after the edge.
  task automatic tick(output logic acc);
    row_t r;
    logic fd_next;
    fd_next = 1'b0;
    acc = in_valid && in_ready && !flush;
    if (row_valid && row_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_row", 64'(row_valid), 64'd0);
      end else begin
        r = sb.pop_front();
        check("row_data", 64'(row_data), 64'(r.data));
        check("row_index", 64'(row_index), 64'(r.idx));
        fd_next = (r.idx == HL'(H - 1)) && !flush;
      end
    end
    @(posedge clk);
    #1;
    cycles++;
    check("frame_done", 64'(frame_done), 64'(fd_next));
  endtask

  task automatic idle(input int n);
    logic acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic send(input logic [7:0] d, input int w, input int h);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    in_valid        = 1'b1;
    in_data         = d;
    in_width_index  = WL'(w);
    in_height_index = HL'(h);
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    check("send_accepted", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic push_row(input logic [31:0] d, input int idx);
    row_t r;
    r.data = d;
    r.idx  = HL'(idx);
    sb.push_back(r);
  endtask

  task automatic do_flush();
    logic acc;
    flush = 1'b1;
    tick(acc);
    flush = 1'b0;
  endtask

  // Full frame with base value b; element k gets b+k.
  task automatic send_frame(input logic [7:0] b);
    for (int r = 0; r < H; r++) begin
      push_row({b + 8'(4*r+3), b + 8'(4*r+2), b + 8'(4*r+1), b + 8'(4*r)}, r);
    end
    for (int k = 0; k < W*H; k++) send(b + 8'(k), k % W, k / W);
  endtask

  initial begin
    logic acc;

    // ---------------- Reset state (while held low) ----------------
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_row_valid", 64'(row_valid), 64'd0);
    check("rst_row_data", 64'(row_data), 64'd0);
    check("rst_row_index", 64'(row_index), 64'd0);
    check("rst_seq_error", 64'(seq_error), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- Full frame, row_ready always high ----------------
    row_ready = 1'b1;
    cycles = 0;
    send_frame(8'h00);
    // 12 elements plus the two HOLD cycles of rows 0 and 1.
    check("throughput_cycles", 64'(cycles), 64'd14);
    idle(3);
    check("frame1_seq_error", 64'(seq_error), 64'd0);
    check("frame1_sb_empty", 64'(sb.size()), 64'd0);

    // ---------------- Backpressure on row 0 ----------------
    row_ready = 1'b0;
    push_row(32'h13121110, 0);
    for (int k = 0; k < W; k++) send(8'h10 + 8'(k), k, 0);
    in_valid = 1'b1;
    in_data = 8'h14;
    in_width_index = 2'd0;
    in_height_index = 2'd1;
    for (int i = 0; i < 5; i++) begin
      check("hold_row_valid", 64'(row_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_row_data", 64'(row_data), 64'h13121110);
      tick(acc);
      check("hold_no_accept", 64'(acc), 64'd0);
    end
    row_ready = 1'b1;
    push_row(32'h17161514, 1);
    send(8'h14, 0, 1);
    for (int k = 1; k < W; k++) send(8'h14 + 8'(k), k, 1);
    idle(2);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // ---------------- Out-of-order tag ----------------
    do_flush();
    check("flush_seq_error", 64'(seq_error), 64'd0);
    send(8'hAA, 2, 0);
    idle(1);
    check("seq_error_set", 64'(seq_error), 64'd1);
    push_row(32'h23222120, 0);
    for (int k = 0; k < W; k++) send(8'h20 + 8'(k), k, 0);
    idle(2);
    check("seq_error_sticky", 64'(seq_error), 64'd1);
    check("ooo_sb_empty", 64'(sb.size()), 64'd0);

    // ---------------- Flush mid row 1 ----------------
    send(8'h30, 0, 1);
    send(8'h31, 1, 1);
    do_flush();
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_row_valid", 64'(row_valid), 64'd0);
    check("flush_seq_error2", 64'(seq_error), 64'd0);
    check("flush_row_data_kept", 64'(row_data), 64'h23223130);
    check("flush_row_index_kept", 64'(row_index), 64'd0);
    send_frame(8'h40);
    idle(3);
    check("flush_frame_sb_empty", 64'(sb.size()), 64'd0);
    check("flush_frame_seq_error", 64'(seq_error), 64'd0);

    // ---------------- Reset while holding row 2 ----------------
    push_row(32'h53525150, 0);
    push_row(32'h57565554, 1);
    for (int k = 0; k < 2*W; k++) send(8'h50 + 8'(k), k % W, k / W);
    idle(1);
    row_ready = 1'b0;
    for (int k = 0; k < W; k++) send(8'h58 + 8'(k), k, 2);
    check("row2_held", 64'(row_valid), 64'd1);
    check("row2_index", 64'(row_index), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_row_valid", 64'(row_valid), 64'd0);
    check("async_rst_row_data", 64'(row_data), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    check("async_rst_frame_done", 64'(frame_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    row_ready = 1'b1;
    idle(1);
    push_row(32'h63626160, 0);
    for (int k = 0; k < W; k++) send(8'h60 + 8'(k), k, 0);
    idle(2);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
